// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: first-order sigma-delta modulator driving a 1-bit pulse-density pin.
// A WIDTH-bit code is turned into frames of N = 2**WIDTH output bits. Each frame carries
// exactly `code` ones. A new code is taken only on a frame boundary, so the duty cycle
// never changes in the middle of a frame.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   reset_i        asynchronous active-high reset, clears all state
//   enable_i       run frames while high; when low, stop after the current frame
//   in_data_i      sample code
//   in_valid_i     in_data_i is valid
//   in_ready_o     sample can be accepted this cycle (combinational)
//   dac_out_o      registered pulse-density output
//   frame_start_o  1-cycle pulse on the first bit of each frame
//   underrun_o     1-cycle pulse with frame_start_o when a frame repeats for lack of data
//   busy_o         high in RUN and DRAIN
module sigma_delta_dac #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic             dac_out_o,
   output logic             frame_start_o,
   output logic             underrun_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pend_full_q, pend_full_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic             dac_q, dac_d;
   logic             fs_q, fs_d;
   logic             ur_pend_q, ur_pend_d;
   logic             ur_q, ur_d;

   logic             pend_load;
   logic             accept;
   logic             last_add;
   logic [WIDTH:0]   sum;

   assign sum      = {1'b0, acc_q} + {1'b0, active_q};
   assign last_add = &frame_cnt_q;

   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      acc_d       = acc_q;
      frame_cnt_d = frame_cnt_q;
      dac_d       = 1'b0;
      fs_d        = 1'b0;
      ur_pend_d   = 1'b0;
      // The underrun decision is made on the last add of a frame; delaying it one cycle
      // lines the pulse up with the next frame_start.
      ur_d        = ur_pend_q;
      pend_load   = 1'b0;

      unique case (state_q)
         StIdle: begin
            acc_d       = '0;
            frame_cnt_d = '0;
            if (enable_i && pend_full_q) begin
               pend_load = 1'b1;
               active_d  = pend_q;
               state_d   = StRun;
            end
         end
         StRun: begin
            {dac_d, acc_d} = sum;
            frame_cnt_d    = frame_cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
            fs_d           = (frame_cnt_q == '0);
            if (last_add) begin
               if (!enable_i) begin
                  state_d = StDrain;
               end else if (pend_full_q) begin
                  pend_load = 1'b1;
                  active_d  = pend_q;
               end else begin
                  ur_pend_d = 1'b1;
               end
            end
         end
         StDrain: begin
            // Final frame bit is on the pin this cycle; start the next run from acc=0.
            acc_d       = '0;
            frame_cnt_d = '0;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Pending slot: a load frees it in the same cycle, so a new sample may refill it.
   assign in_ready_o = !pend_full_q || pend_load;
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      if (accept) begin
         pend_d      = in_data_i;
         pend_full_d = 1'b1;
      end else if (pend_load) begin
         pend_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         active_q    <= '0;
         acc_q       <= '0;
         frame_cnt_q <= '0;
         dac_q       <= 1'b0;
         fs_q        <= 1'b0;
         ur_pend_q   <= 1'b0;
         ur_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         active_q    <= active_d;
         acc_q       <= acc_d;
         frame_cnt_q <= frame_cnt_d;
         dac_q       <= dac_d;
         fs_q        <= fs_d;
         ur_pend_q   <= ur_pend_d;
         ur_q        <= ur_d;
      end
   end

   assign dac_out_o     = dac_q;
   assign frame_start_o = fs_q;
   assign underrun_o    = ur_q;
   assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed bench for sigma_delta_dac with WIDTH=4 (16-cycle frames).
module tb_sigma_delta_dac;

   localparam int unsigned W = 4;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         dac_out;
   logic         frame_start;
   logic         underrun;
   logic         busy;

   int passed = 0;
   int total  = 0;

   sigma_delta_dac #(.WIDTH(W)) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .enable_i     (enable),
      .in_data_i    (in_data),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .dac_out_o    (dac_out),
      .frame_start_o(frame_start),
      .underrun_o   (underrun),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fs(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (frame_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Called on a frame_start sample; collects that bit and the following N-1 bits.
   task automatic capture(output logic [N-1:0] bits, output int ones, output bit ur0,
                          output int ur_n, output int fs_n);
      bits    = '0;
      bits[0] = dac_out;
      ones    = (dac_out === 1'b1) ? 1 : 0;
      ur0     = (underrun === 1'b1);
      ur_n    = 0;
      fs_n    = 0;
      for (int i = 1; i < N; i++) begin
         step();
         bits[i] = dac_out;
         ones += (dac_out === 1'b1) ? 1 : 0;
         ur_n += (underrun === 1'b1) ? 1 : 0;
         fs_n += (frame_start === 1'b1) ? 1 : 0;
      end
   endtask

   task automatic push(input logic [W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic go_idle(output bit ok);
      enable = 1'b0;
      ok     = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      total++; if (dac_out !== 1'b0) $display("FAIL reset_dac got %b want 0", dac_out); else passed++;
      total++; if (frame_start !== 1'b0) $display("FAIL reset_fs got %b want 0", frame_start); else passed++;
      total++; if (underrun !== 1'b0) $display("FAIL reset_ur got %b want 0", underrun); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else passed++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_code5();
      bit ok, ur0;
      logic [N-1:0] bits;
      int ones, ur_n, fs_n;
      enable = 1'b1;
      push(4'd5);
      wait_fs(ok);
      total++; if (ok !== 1'b1) $display("FAIL c5_fs_timeout got %b want 1", ok); else passed++;
      capture(bits, ones, ur0, ur_n, fs_n);
      total++; if (ones != 5) $display("FAIL c5_ones got %0d want 5", ones); else passed++;
      total++; if (bits !== 16'b1001_0010_0100_1000) $display("FAIL c5_pattern got %b want 1001001001001000", bits); else passed++;
      total++; if (ur0 !== 1'b0 || fs_n != 0) $display("FAIL c5_first_flags got ur=%b fs_n=%0d want 0 0", ur0, fs_n); else passed++;
      step();
      total++; if (frame_start !== 1'b1) $display("FAIL c5_period got %b want 1", frame_start); else passed++;
      capture(bits, ones, ur0, ur_n, fs_n);
      total++; if (ones != 5) $display("FAIL c5_ones2 got %0d want 5", ones); else passed++;
      total++; if (ur0 !== 1'b1) $display("FAIL c5_ur2 got %b want 1", ur0); else passed++;
      go_idle(ok);
      total++; if (ok !== 1'b1) $display("FAIL c5_idle got %b want 1", ok); else passed++;
   endtask

   task automatic test_back_to_back();
      bit ok, ur0;
      bit [2:0] oks;
      logic [N-1:0] bits;
      int ones [3];
      int ur_n, fs_n, w;
      enable   = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'd0;
      step();
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_load got %b want 1", in_ready); else passed++;
      in_data = 4'd15;
      step();
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_full got %b want 0", in_ready); else passed++;
      w = 0;
      fork
         begin
            in_valid = 1'b1;
            in_data  = 4'd1;
            while (in_ready !== 1'b1 && w < 40) begin
               step();
               w++;
            end
            step();
            in_valid = 1'b0;
         end
         begin
            for (int f = 0; f < 3; f++) begin
               wait_fs(ok);
               oks[f] = ok;
               capture(bits, ones[f], ur0, ur_n, fs_n);
            end
         end
      join
      total++; if (w != 15) $display("FAIL b2b_ready_wait got %0d want 15", w); else passed++;
      total++; if (oks !== 3'b111) $display("FAIL b2b_fs_timeout got %b want 111", oks); else passed++;
      total++; if (ones[0] != 0) $display("FAIL b2b_frame0 got %0d want 0", ones[0]); else passed++;
      total++; if (ones[1] != 15) $display("FAIL b2b_frame1 got %0d want 15", ones[1]); else passed++;
      total++; if (ones[2] != 1) $display("FAIL b2b_frame2 got %0d want 1", ones[2]); else passed++;
      go_idle(ok);
      total++; if (ok !== 1'b1) $display("FAIL b2b_idle got %b want 1", ok); else passed++;
   endtask

   task automatic test_underrun();
      bit ok, ur0;
      logic [N-1:0] bits;
      int ones, ur_n, fs_n;
      enable = 1'b1;
      push(4'd9);
      wait_fs(ok);
      capture(bits, ones, ur0, ur_n, fs_n);
      total++; if (ones != 9 || ur0 !== 1'b0) $display("FAIL ur_frame1 got ones=%0d ur=%b want 9 0", ones, ur0); else passed++;
      for (int f = 0; f < 2; f++) begin
         wait_fs(ok);
         total++; if (ok !== 1'b1) $display("FAIL ur_fs_timeout got %b want 1", ok); else passed++;
         capture(bits, ones, ur0, ur_n, fs_n);
         total++; if (ones != 9) $display("FAIL ur_repeat_ones got %0d want 9", ones); else passed++;
         total++; if (ur0 !== 1'b1 || ur_n != 0) $display("FAIL ur_pulse got start=%b rest=%0d want 1 0", ur0, ur_n); else passed++;
      end
      go_idle(ok);
      total++; if (ok !== 1'b1) $display("FAIL ur_idle got %b want 1", ok); else passed++;
   endtask

   task automatic test_disable();
      bit ok, ur0;
      logic [N-1:0] bits;
      int ones, ur_n, fs_n, quiet;
      enable = 1'b1;
      push(4'd7);
      wait_fs(ok);
      ones = (dac_out === 1'b1) ? 1 : 0;
      for (int i = 1; i < N; i++) begin
         step();
         ones += (dac_out === 1'b1) ? 1 : 0;
         if (i == 7) enable = 1'b0;
      end
      total++; if (ones != 7) $display("FAIL dis_frame_ones got %0d want 7", ones); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL dis_drain_busy got %b want 1", busy); else passed++;
      step();
      total++; if (busy !== 1'b0 || dac_out !== 1'b0) $display("FAIL dis_idle got busy=%b dac=%b want 0 0", busy, dac_out); else passed++;
      push(4'd3);
      quiet = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         quiet += (dac_out === 1'b1 || busy === 1'b1) ? 1 : 0;
      end
      total++; if (quiet != 0) $display("FAIL dis_stays_idle got %0d active cycles want 0", quiet); else passed++;
      enable = 1'b1;
      wait_fs(ok);
      capture(bits, ones, ur0, ur_n, fs_n);
      total++; if (ones != 3 || ur0 !== 1'b0) $display("FAIL dis_reenable got ones=%0d ur=%b want 3 0", ones, ur0); else passed++;
      go_idle(ok);
      total++; if (ok !== 1'b1) $display("FAIL dis_idle2 got %b want 1", ok); else passed++;
   endtask

   task automatic test_mid_reset();
      bit ok, ur0;
      logic [N-1:0] bits;
      int ones, ur_n, fs_n;
      enable = 1'b1;
      push(4'd12);
      wait_fs(ok);
      push(4'd4);
      for (int i = 2; i <= 10; i++) step();
      reset = 1'b1;
      #1;
      total++; if (dac_out !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_out got dac=%b busy=%b want 0 0", dac_out, busy); else passed++;
      total++; if (in_ready !== 1'b1 || frame_start !== 1'b0) $display("FAIL rst_mid_ready got rdy=%b fs=%b want 1 0", in_ready, frame_start); else passed++;
      step();
      total++; if (frame_start !== 1'b0 || dac_out !== 1'b0) $display("FAIL rst_hold got fs=%b dac=%b want 0 0", frame_start, dac_out); else passed++;
      reset = 1'b0;
      step();
      step();
      step();
      total++; if (busy !== 1'b0) $display("FAIL rst_pending_cleared got busy=%b want 0", busy); else passed++;
      push(4'd12);
      wait_fs(ok);
      capture(bits, ones, ur0, ur_n, fs_n);
      total++; if (ones != 12) $display("FAIL rst_clean_frame got %0d want 12", ones); else passed++;
      go_idle(ok);
      total++; if (ok !== 1'b1) $display("FAIL rst_idle got %b want 1", ok); else passed++;
   endtask

   task automatic test_hold_valid();
      bit ok, ur0;
      bit [3:0] oks;
      logic [N-1:0] bits;
      int ones [4];
      int ur_n, fs_n, rdy_n;
      enable = 1'b1;
      rdy_n  = 0;
      fork
         begin
            for (int k = 0; k <= 40; k++) begin
               in_valid = 1'b1;
               in_data  = 4'((k * 5 + (k / 16) * 3 + 1) & 15);
               if (in_ready === 1'b1) rdy_n++;
               step();
            end
            in_valid = 1'b0;
         end
         begin
            for (int f = 0; f < 4; f++) begin
               wait_fs(ok);
               oks[f] = ok;
               capture(bits, ones[f], ur0, ur_n, fs_n);
            end
         end
      join
      total++; if (rdy_n != 4) $display("FAIL hold_ready_cycles got %0d want 4", rdy_n); else passed++;
      total++; if (oks !== 4'b1111) $display("FAIL hold_fs_timeout got %b want 1111", oks); else passed++;
      total++; if (ones[0] != 1 || ones[1] != 6) $display("FAIL hold_frames01 got %0d %0d want 1 6", ones[0], ones[1]); else passed++;
      total++; if (ones[2] != 9 || ones[3] != 12) $display("FAIL hold_frames23 got %0d %0d want 9 12", ones[2], ones[3]); else passed++;
      go_idle(ok);
      total++; if (ok !== 1'b1) $display("FAIL hold_idle got %b want 1", ok); else passed++;
   endtask

   initial begin
      test_reset();
      test_code5();
      test_back_to_back();
      test_underrun();
      test_disable();
      test_mid_reset();
      test_hold_valid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
